// File: rtl/imem_stream_loader_if.sv
// rtl/imem_stream_loader_if.sv - byte stream, imem write port and core control bundle for imem_stream_loader
//
// Signals:
//   load_start_i / load_len_i : load request and word count (ADDR_W+1 bits)
//   byte_valid_i / byte_data_i / byte_ready_o : incoming byte stream handshake
//   imem_we_o / imem_addr_o / imem_wdata_o : instruction-memory write port
//   core_rst_n_o, load_busy_o, load_done_o, load_err_o : core reset and status
// Modports:
//   slave  : the loader (receives requests and bytes, drives memory and status)
//   master : the requester / stream source side
interface imem_stream_loader_if #(
  parameter int ADDR_W = 12
);
  logic              load_start_i;
  logic [ADDR_W:0]   load_len_i;
  logic              byte_valid_i;
  logic [7:0]        byte_data_i;
  logic              byte_ready_o;
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_wdata_o;
  logic              core_rst_n_o;
  logic              load_busy_o;
  logic              load_done_o;
  logic              load_err_o;

  modport slave (
    input  load_start_i, load_len_i, byte_valid_i, byte_data_i,
    output byte_ready_o, imem_we_o, imem_addr_o, imem_wdata_o,
           core_rst_n_o, load_busy_o, load_done_o, load_err_o
  );

  modport master (
    output load_start_i, load_len_i, byte_valid_i, byte_data_i,
    input  byte_ready_o, imem_we_o, imem_addr_o, imem_wdata_o,
           core_rst_n_o, load_busy_o, load_done_o, load_err_o
  );
endinterface

// File: rtl/imem_stream_loader.sv
// rtl/imem_stream_loader.sv - byte-stream loader for the RV32I instruction memory
//
// Assembles little-endian 32-bit words from a byte stream and writes them to
// consecutive instruction-memory word addresses starting at 0, holding the
// core in reset during the load and for RST_HOLD cycles after the last write.
//
// Ports:
//   sys_clk_i : system clock, rising edge
//   rst_i     : asynchronous active-high reset
//   bus       : imem_stream_loader_if.slave (request, byte stream, imem write
//               port, core reset and status)
// Parameters:
//   ADDR_W    : imem word-address width, depth = 2^ADDR_W words
//   RST_HOLD  : cycles the core stays in reset after the last write (1..255)
// Build option:
//   IMEM_LOADER_CHECKSUM_EN : after the last word, 4 more bytes carry the
//   expected 32-bit sum of all written words; a mismatch aborts with an error
//   pulse and keeps the core in reset.
module imem_stream_loader #(
  parameter int ADDR_W   = 12,
  parameter int RST_HOLD = 8
) (
  input  logic                sys_clk_i,
  input  logic                rst_i,
  imem_stream_loader_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [7:0]      HOLD_LAST = 8'(RST_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_HOLD,
    S_CHK
  } state_t;

  state_t            state;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   word_cnt;
  logic [1:0]        byte_cnt;
  logic [7:0]        hold_cnt;
  logic [31:0]       word_q;
  logic              ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              core_rst_n_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]       sum_q;
`endif

  logic              accept;
  logic              len_ok;
  logic [31:0]       word_nxt;
  logic [ADDR_W:0]   word_cnt_inc;

  assign accept       = bus.byte_valid_i & ready_q;
  assign len_ok       = (bus.load_len_i != '0) && (bus.load_len_i <= DEPTH);
  assign word_cnt_inc = word_cnt + 1'b1;

  // Current byte dropped into its little-endian lane of the word being built.
  always_comb begin
    word_nxt = word_q;
    case (byte_cnt)
      2'd0: word_nxt[7:0]   = bus.byte_data_i;
      2'd1: word_nxt[15:8]  = bus.byte_data_i;
      2'd2: word_nxt[23:16] = bus.byte_data_i;
      default: word_nxt[31:24] = bus.byte_data_i;
    endcase
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      len_q        <= '0;
      word_cnt     <= '0;
      byte_cnt     <= '0;
      hold_cnt     <= '0;
      word_q       <= '0;
      ready_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.load_start_i) begin
            if (len_ok) begin
              len_q        <= bus.load_len_i;
              word_cnt     <= '0;
              byte_cnt     <= '0;
              core_rst_n_q <= 1'b0;
              done_q       <= 1'b0;
              busy_q       <= 1'b1;
              ready_q      <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
              sum_q        <= '0;
`endif
              state        <= S_RECV;
            end else begin
              // Rejected request leaves core reset and done untouched.
              err_q <= 1'b1;
            end
          end
        end

        S_RECV: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            word_q   <= word_nxt;
            if (byte_cnt == 2'd3) begin
              // Write strobe is registered here so it appears in the cycle
              // right after the 4th byte; ready drops for that cycle.
              ready_q <= 1'b0;
              we_q    <= 1'b1;
              addr_q  <= word_cnt[ADDR_W-1:0];
              wdata_q <= word_nxt;
              state   <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          we_q     <= 1'b0;
          word_cnt <= word_cnt_inc;
          hold_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_q    <= sum_q + wdata_q;
`endif
          if (word_cnt_inc == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            ready_q <= 1'b1;
            state   <= S_CHK;
`else
            state   <= S_HOLD;
`endif
          end else begin
            ready_q <= 1'b1;
            state   <= S_RECV;
          end
        end

        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            core_rst_n_q <= 1'b1;
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
            state        <= S_IDLE;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          // Checksum bytes reuse the word assembler but are never written.
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            word_q   <= word_nxt;
            if (byte_cnt == 2'd3) begin
              ready_q <= 1'b0;
              if (word_nxt == sum_q) begin
                state <= S_HOLD;
              end else begin
                err_q  <= 1'b1;
                busy_q <= 1'b0;
                state  <= S_IDLE;
              end
            end
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.byte_ready_o = ready_q;
  assign bus.imem_we_o    = we_q;
  assign bus.imem_addr_o  = addr_q;
  assign bus.imem_wdata_o = wdata_q;
  assign bus.core_rst_n_o = core_rst_n_q;
  assign bus.load_busy_o  = busy_q;
  assign bus.load_done_o  = done_q;
  assign bus.load_err_o   = err_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// tb/tb_imem_stream_loader.sv - directed self-checking bench for imem_stream_loader
module tb_imem_stream_loader;

  localparam int ADDR_W   = 4;
  localparam int RST_HOLD = 8;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  imem_stream_loader_if #(.ADDR_W(ADDR_W)) bif ();

  imem_stream_loader #(.ADDR_W(ADDR_W), .RST_HOLD(RST_HOLD)) dut (
    .sys_clk_i (clk),
    .rst_i     (rst),
    .bus       (bif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Monitor: records writes, checks write latency and ready during WRITE,
  // counts error cycles and measures quiet hold cycles before core release.
  logic [ADDR_W-1:0] obs_addr[$];
  logic [31:0]       obs_data[$];
  int  bcnt      = 0;
  bit  last4     = 0;
  int  err_cycles = 0;
  int  quiet     = 0;
  int  hold_gap  = -1;
  bit  prev_crst = 0;

  always @(negedge clk) begin
    if (rst) begin
      bcnt  = 0;
      last4 = 0;
    end else begin
      if (bif.imem_we_o) begin
        obs_addr.push_back(bif.imem_addr_o);
        obs_data.push_back(bif.imem_wdata_o);
        check("we_after_4th_byte", 32'(last4), 32'd1);
        check("ready_low_in_write", 32'(bif.byte_ready_o), 32'd0);
      end
      last4 = 0;
      if (bif.byte_valid_i && bif.byte_ready_o) begin
        if (bcnt == 3) begin
          last4 = 1;
          bcnt  = 0;
        end else begin
          bcnt++;
        end
      end
    end
    if (bif.load_err_o) err_cycles++;
    if (bif.core_rst_n_o && !prev_crst) hold_gap = quiet;
    if (bif.imem_we_o || bif.byte_ready_o || !bif.load_busy_o) quiet = 0;
    else quiet++;
    prev_crst = bif.core_rst_n_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int len);
    bif.load_start_i = 1'b1;
    bif.load_len_i   = (ADDR_W+1)'(len);
    tick();
    bif.load_start_i = 1'b0;
    bif.load_len_i   = '0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) tick();
    bif.byte_valid_i = 1'b1;
    bif.byte_data_i  = b;
    n = 0;
    while (!bif.byte_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("ready_timeout", 32'd0, 32'd1);
    tick();
    bif.byte_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic send_chk(input logic [31:0] s);
    if (CHK_EN) send_word(s, 0);
  endtask

  task automatic wait_release();
    int n;
    n = 0;
    while (!bif.core_rst_n_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("release_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
  endtask

  int e0;
  logic [31:0] sum;
  logic [31:0] w;

  initial begin
    bif.load_start_i = 1'b0;
    bif.load_len_i   = '0;
    bif.byte_valid_i = 1'b0;
    bif.byte_data_i  = '0;

    // Reset state
    repeat (3) tick();
    check("rst_ready", 32'(bif.byte_ready_o), 32'd0);
    check("rst_we", 32'(bif.imem_we_o), 32'd0);
    check("rst_addr", 32'(bif.imem_addr_o), 32'd0);
    check("rst_wdata", bif.imem_wdata_o, 32'd0);
    check("rst_core_rst_n", 32'(bif.core_rst_n_o), 32'd0);
    check("rst_busy", 32'(bif.load_busy_o), 32'd0);
    check("rst_done", 32'(bif.load_done_o), 32'd0);
    check("rst_err", 32'(bif.load_err_o), 32'd0);
    rst = 1'b0;
    tick();

    // len=0 rejected
    e0 = err_cycles;
    start_load(0);
    check("len0_err_now", 32'(bif.load_err_o), 32'd1);
    tick(); tick();
    check("len0_err_cycles", 32'(err_cycles - e0), 32'd1);
    check("len0_stay_idle_busy", 32'(bif.load_busy_o), 32'd0);
    check("len0_stay_idle_ready", 32'(bif.byte_ready_o), 32'd0);
    check("len0_core_held", 32'(bif.core_rst_n_o), 32'd0);

    // len=2 basic load
    clear_obs();
    start_load(2);
    check("l2_busy", 32'(bif.load_busy_o), 32'd1);
    check("l2_ready", 32'(bif.byte_ready_o), 32'd1);
    send_word(32'h0000_0013, 0);
    send_word(32'h0000_006F, 0);
    send_chk(32'h0000_0082);
    wait_release();
    check("l2_nwrites", 32'(obs_addr.size()), 32'd2);
    if (obs_addr.size() == 2) begin
      check("l2_addr0", 32'(obs_addr[0]), 32'd0);
      check("l2_data0", obs_data[0], 32'h0000_0013);
      check("l2_addr1", 32'(obs_addr[1]), 32'd1);
      check("l2_data1", obs_data[1], 32'h0000_006F);
    end
    check("l2_hold_cycles", 32'(hold_gap), 32'(RST_HOLD));
    check("l2_done", 32'(bif.load_done_o), 32'd1);
    check("l2_busy_end", 32'(bif.load_busy_o), 32'd0);
    check("l2_core_run", 32'(bif.core_rst_n_o), 32'd1);
    check("l2_hold_addr", 32'(bif.imem_addr_o), 32'd1);
    check("l2_hold_wdata", bif.imem_wdata_o, 32'h0000_006F);

    // len > depth rejected, done and core state unchanged
    e0 = err_cycles;
    start_load(17);
    tick(); tick();
    check("len17_err_cycles", 32'(err_cycles - e0), 32'd1);
    check("len17_done_kept", 32'(bif.load_done_o), 32'd1);
    check("len17_core_kept", 32'(bif.core_rst_n_o), 32'd1);
    check("len17_busy", 32'(bif.load_busy_o), 32'd0);

    // Backpressure: gap between every byte
    clear_obs();
    start_load(2);
    check("bp_core_held", 32'(bif.core_rst_n_o), 32'd0);
    check("bp_done_clr", 32'(bif.load_done_o), 32'd0);
    send_word(32'h0000_0013, 1);
    send_word(32'h0000_006F, 1);
    send_chk(32'h0000_0082);
    wait_release();
    check("bp_nwrites", 32'(obs_addr.size()), 32'd2);
    if (obs_addr.size() == 2) begin
      check("bp_data0", obs_data[0], 32'h0000_0013);
      check("bp_data1", obs_data[1], 32'h0000_006F);
      check("bp_addr1", 32'(obs_addr[1]), 32'd1);
    end

    // load_start_i mid-RECV ignored
    clear_obs();
    e0 = err_cycles;
    start_load(2);
    send_byte(8'hEF, 0);
    send_byte(8'hBE, 0);
    bif.load_start_i = 1'b1;
    bif.load_len_i   = '0;
    tick();
    bif.load_start_i = 1'b0;
    send_byte(8'hAD, 0);
    send_byte(8'hDE, 0);
    send_word(32'h0000_0093, 0);
    send_chk(32'hDEAD_BEEF + 32'h0000_0093);
    wait_release();
    check("mid_no_err", 32'(err_cycles - e0), 32'd0);
    check("mid_nwrites", 32'(obs_addr.size()), 32'd2);
    if (obs_addr.size() == 2) begin
      check("mid_data0", obs_data[0], 32'hDEAD_BEEF);
      check("mid_data1", obs_data[1], 32'h0000_0093);
    end
    check("mid_done", 32'(bif.load_done_o), 32'd1);

    // Reset after 5 bytes of a len=4 load
    clear_obs();
    start_load(4);
    send_word(32'h1122_3344, 0);
    send_byte(8'h55, 0);
    check("pre_rst_wdata", bif.imem_wdata_o, 32'h1122_3344);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ready", 32'(bif.byte_ready_o), 32'd0);
    check("arst_busy", 32'(bif.load_busy_o), 32'd0);
    check("arst_wdata", bif.imem_wdata_o, 32'd0);
    check("arst_addr", 32'(bif.imem_addr_o), 32'd0);
    check("arst_core", 32'(bif.core_rst_n_o), 32'd0);
    check("arst_done", 32'(bif.load_done_o), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    clear_obs();
    start_load(1);
    send_word(32'hA5A5_0F0F, 0);
    send_chk(32'hA5A5_0F0F);
    wait_release();
    check("after_rst_nwrites", 32'(obs_addr.size()), 32'd1);
    if (obs_addr.size() == 1) begin
      check("after_rst_addr", 32'(obs_addr[0]), 32'd0);
      check("after_rst_data", obs_data[0], 32'hA5A5_0F0F);
    end
    check("after_rst_done", 32'(bif.load_done_o), 32'd1);

    // Full-depth load: 16 words, last address 15
    clear_obs();
    e0 = err_cycles;
    sum = '0;
    start_load(16);
    for (int i = 0; i < 16; i++) begin
      w = 32'h1000_0000 + 32'(i) * 32'h0000_0111;
      sum += w;
      send_word(w, 0);
    end
    send_chk(sum);
    wait_release();
    check("full_no_err", 32'(err_cycles - e0), 32'd0);
    check("full_nwrites", 32'(obs_addr.size()), 32'd16);
    if (obs_addr.size() == 16) begin
      check("full_last_addr", 32'(obs_addr[15]), 32'd15);
      check("full_last_data", obs_data[15], 32'h1000_0FFF);
      check("full_addr7", 32'(obs_addr[7]), 32'd7);
    end
    check("full_done", 32'(bif.load_done_o), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum match
    clear_obs();
    start_load(2);
    send_word(32'h0000_0001, 0);
    send_word(32'h0000_0002, 0);
    send_word(32'h0000_0003, 0);
    wait_release();
    check("cs_ok_done", 32'(bif.load_done_o), 32'd1);
    check("cs_ok_core", 32'(bif.core_rst_n_o), 32'd1);
    check("cs_ok_nwrites", 32'(obs_addr.size()), 32'd2);
    check("cs_ok_hold", 32'(hold_gap), 32'(RST_HOLD));

    // Checksum mismatch
    e0 = err_cycles;
    start_load(2);
    send_word(32'h0000_0001, 0);
    send_word(32'h0000_0002, 0);
    send_word(32'h0000_0004, 0);
    repeat (RST_HOLD + 4) tick();
    check("cs_bad_err", 32'(err_cycles - e0), 32'd1);
    check("cs_bad_core", 32'(bif.core_rst_n_o), 32'd0);
    check("cs_bad_done", 32'(bif.load_done_o), 32'd0);
    check("cs_bad_busy", 32'(bif.load_busy_o), 32'd0);
`endif

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Upstream feeder of the RV32I core's instruction memory.
- Accepts a byte stream over valid/ready, assembles little-endian 32-bit words and writes them sequentially into the instruction-memory write port.
- Holds the core in reset while loading; releases it after the last word plus a fixed hold time.
- Gives bench and board bring-up a synthesizable alternative to backdoor $readmemh loading when running rv32ui test images.

Parameters:
- ADDR_W, 12, instruction-memory word-address width; depth = 2^ADDR_W words.
- RST_HOLD, 8, cycles core reset stays asserted after the last write (1..255).

Ports:
- sys_clk_i  in  1  single system clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- load_start_i  in  1  one-cycle request to begin a new load; sampled only in IDLE.
- load_len_i  in  ADDR_W+1  number of 32-bit words to load; sampled with load_start_i.
- byte_valid_i  in  1  stream byte valid.
- byte_data_i  in  8  stream byte.
- byte_ready_o  out  1  loader can accept a byte.
- imem_we_o  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr_o  out  ADDR_W  word address of the write.
- imem_wdata_o  out  32  word to write.
- core_rst_n_o  out  1  active-low reset to the core; 0 = core held.
- load_busy_o  out  1  high in RECV, WRITE, HOLD (and CHK when enabled).
- load_done_o  out  1  level; high after a successful load until the next accepted load_start_i.
- load_err_o  out  1  one-cycle pulse on a rejected request or checksum mismatch.

Behaviour:
- Reset (async): state=IDLE; all counters 0; byte_ready_o=0, imem_we_o=0, imem_addr_o=0, imem_wdata_o=0, core_rst_n_o=0, load_busy_o=0, load_done_o=0, load_err_o=0.
- IDLE:
  - load_start_i with 1 <= load_len_i <= 2^ADDR_W: latch len; clear word_cnt and byte_cnt; core_rst_n_o=0; load_done_o=0; go to RECV.
  - load_start_i with len 0 or > 2^ADDR_W: load_err_o=1 for one cycle; stay in IDLE; core_rst_n_o and load_done_o unchanged.
- RECV:
  - byte_ready_o=1.
  - On valid&ready, byte lands at bits [8*byte_cnt+7 : 8*byte_cnt] (first byte is bits 7:0); byte_cnt increments.
  - On acceptance of the 4th byte: byte_cnt wraps to 0, go to WRITE. byte_ready_o is 0 from the next cycle.
- WRITE (exactly 1 cycle):
  - imem_we_o=1, imem_addr_o=word_cnt[ADDR_W-1:0], imem_wdata_o=assembled word.
  - Timing: a 4th byte accepted at edge N gives imem_we_o high in cycle N+1.
  - word_cnt increments. If the new word_cnt == len, go to HOLD (or CHK when enabled); otherwise go back to RECV.
- HOLD:
  - Counts RST_HOLD cycles with core_rst_n_o=0.
  - Then: core_rst_n_o=1, load_done_o=1, load_busy_o=0, go to IDLE.
- load_start_i outside IDLE is ignored with no error.
- Bytes are never accepted outside RECV.
- A full-depth load (len=2^ADDR_W) writes last address 2^ADDR_W-1. word_cnt is ADDR_W+1 bits, so there is no wrap.
- A reset asserted mid-load aborts immediately to the reset values. Memory contents already written are left as is.
- imem_addr_o and imem_wdata_o hold their last values when imem_we_o=0.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A 32-bit running sum (mod 2^32) of all written words is kept.
  - After the last WRITE, state CHK accepts 4 more bytes (little-endian) as the expected sum; these bytes are not written to memory.
  - Match: go to HOLD as normal.
  - Mismatch: load_err_o pulses for 1 cycle, go to IDLE, core_rst_n_o stays 0, load_done_o stays 0.
- Not defined: no CHK state; the last WRITE goes directly to HOLD.

Test Plan:
- Reset then idle:
  - All outputs at reset values, core_rst_n_o=0.
  - load_start_i with len=0 -> load_err_o pulses 1 cycle; state stays IDLE.
- len=2, bytes 13 00 00 00 6F 00 00 00:
  - imem_we_o pulses at addr 0 with 0x00000013, then at addr 1 with 0x0000006F.
  - core_rst_n_o rises exactly RST_HOLD=8 cycles after the second write; load_done_o=1.
- Backpressure and gaps:
  - byte_valid_i toggled every other cycle -> same written words.
  - Each imem_we_o is exactly 1 cycle after its 4th byte; byte_ready_o=0 during WRITE.
- load_start_i pulsed mid-RECV -> ignored, no error, load completes normally.
- rst_i asserted after 5 bytes of a len=4 load:
  - All outputs return to reset values asynchronously.
  - A new len=1 load then writes addr 0 correctly.
- With IMEM_LOADER_CHECKSUM_EN, words 0x00000001 and 0x00000002:
  - Checksum bytes 03 00 00 00 -> done, core released.
  - Checksum bytes 04 00 00 00 -> load_err_o pulses, core_rst_n_o stays 0.
